alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control-side initiator for the multi-stage ALU datapath and shared bus.
- Decodes one instruction at a time and drives, cycle by cycle, the register-file tristate enables, the A-register load, the G-register load and the G-to-bus enable.
- Reports completion to the surrounding processor control.
- Sits between instruction fetch (INSTR/RUN) and the A/G register plus tristate datapath.

Parameters:
- N, 10, instruction width; fixed layout OP[9:6], X[5:3], Y[2:0].
- NREG, 8, number of general registers; width of the Rin/Rout one-hot vectors; valid range 1..8.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- INSTR  in  N  instruction word; sampled only when accepted.
- RUN  in  1  start request.
- Rin  out  NREG  one-hot register load enable.
- Rout  out  NREG  one-hot register tristate-to-bus enable.
- DINout  out  1  drive immediate data onto bus.
- enA  out  1  load A register from bus.
- enGin  out  1  load G register from ALU result.
- enGout  out  1  G tristate-to-bus enable.
- ALUOP  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(A).
- BUSY  out  1  high whenever state is not IDLE.
- DONE  out  1  one-cycle pulse in the final step of an instruction.

Behaviour:
- Single clock domain; RST is synchronous and active-high.
- Internal IR (N bits) is loaded from INSTR on the clock edge where state is IDLE and RUN=1. RUN is ignored in all other states.
- Opcodes: 0 MV, 1 MVI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT. Codes 8-15 are reserved.
- States: IDLE, T1, T2, T3.
  - IDLE: all outputs 0. RUN=1 -> T1.
  - T1, MV: Rout[Y]=1, Rin[X]=1, DONE=1 -> IDLE.
  - T1, MVI: DINout=1, Rin[X]=1, DONE=1 -> IDLE.
  - T1, ALU ops (2-7): Rout[X]=1, enA=1 -> T2.
  - T1, reserved or index >= NREG: DONE=1, no other output -> IDLE.
  - T2, ops 2-6: Rout[Y]=1, enGin=1, ALUOP per op -> T3.
  - T2, NOT: Rout all 0, enGin=1, ALUOP=5 -> T3.
  - T3: enGout=1, Rin[X]=1, DONE=1 -> IDLE.
- Outputs are a Moore decode of state and IR (combinational from registered state). ALUOP=0 outside T2.
- Latency, counted from the RUN-accept edge: MV/MVI/NOP DONE in cycle 1; ALU ops DONE in cycle 3. Minimum issue interval: 2 cycles (MV) or 4 cycles (ALU), because one IDLE cycle always follows DONE.
- Bus invariant: at most one of {any Rout bit, DINout, enGout} is high in any cycle. Rin and Rout are each at most one-hot.
- X==Y is legal. Example: ADD R3,R3 doubles R3.
- RST in any state: next cycle state=IDLE, IR=0, all outputs 0. An in-flight instruction is abandoned with no DONE. RST has priority over RUN.
- INSTR changes after acceptance have no effect.

Optional Feature:
- Macro: SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output ILLEGAL (1 bit) and state TRAP.
  - A reserved opcode, or X/Y >= NREG, at T1 -> TRAP. No DONE is issued.
  - In TRAP: ILLEGAL=1, BUSY=1, all bus controls 0, RUN ignored.
  - Only RST leaves TRAP.
- Undefined:
  - No ILLEGAL port.
  - Illegal instructions complete as a 1-cycle NOP with DONE.

Test Plan:
- Reset: RST=1 for 2 cycles, then RUN=1 with INSTR=ADD R1,R2 (0x08A). Expect BUSY=0 and all outputs 0 during reset; then T1 Rout=0x02, enA=1.
- ADD R1,R2 (OP=2, X=1, Y=2):
  - T1: Rout=0x02, enA=1.
  - T2: Rout=0x04, enGin=1, ALUOP=0.
  - T3: enGout=1, Rin=0x02, DONE=1.
  - Then IDLE. Bus invariant holds every cycle.
- MVI R5 (0x068): T1 has DINout=1, Rin=0x20, DONE=1; next cycle BUSY=0. A MV R0,R7 (0x007) issued next gives Rout=0x80, Rin=0x01.
- NOT R4 (0x1E0): T2 has Rout=0x00, enGin=1, ALUOP=5; T3 has enGout=1, Rin=0x10.
- Reset mid-op: RST asserted during T2 of SUB R6,R1 (0x0F1). Next cycle IDLE with all outputs 0 and no DONE. RUN held high throughout is ignored until RST drops.
- Reserved opcode 0x3C0:
  - Without the macro: DONE in cycle 1, no other enables.
  - With SEQ_ILLEGAL_TRAP_EN: ILLEGAL=1 and BUSY=1 held for 10 cycles with RUN pulsing; cleared by RST.

Source files
------------

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the multi-stage ALU/bus datapath: decodes one instruction
// at a time into per-step bus controls. Optional illegal-instruction trap: SEQ_ILLEGAL_TRAP_EN.
module alu_sequencer #(
    parameter int N    = 10,
    parameter int NREG = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    INSTR,
    input  logic            RUN,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            DINout,
    output logic            enA,
    output logic            enGin,
    output logic            enGout,
    output logic [2:0]      ALUOP,
    output logic            BUSY,
    output logic            DONE
`ifdef SEQ_ILLEGAL_TRAP_EN
    ,
    output logic            ILLEGAL
`endif
);

`ifdef SEQ_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {IDLE, T1, T2, T3, TRAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
`endif

    state_t         state;
    state_t         next;
    logic [N-1:0]   ir;
    logic [3:0]     op;
    logic [2:0]     x;
    logic [2:0]     y;
    logic           illegal;

    assign op = ir[N-1:N-4];
    assign x  = ir[5:3];
    assign y  = ir[2:0];

    // Reserved opcodes occupy the upper half of the opcode space.
    assign illegal = op[3] || (32'(x) >= NREG) || (32'(y) >= NREG);

    function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NREG; i++)
            v[i] = (32'(idx) == i);
        return v;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= next;
            if (state == IDLE && RUN)
                ir <= INSTR;
        end
    end

    always_comb begin
        next   = state;
        Rin    = '0;
        Rout   = '0;
        DINout = 1'b0;
        enA    = 1'b0;
        enGin  = 1'b0;
        enGout = 1'b0;
        ALUOP  = 3'd0;
        DONE   = 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
        ILLEGAL = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (RUN)
                    next = T1;
            end
            T1: begin
                if (illegal) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                    next = TRAP;
`else
                    DONE = 1'b1;
                    next = IDLE;
`endif
                end else if (op == 4'd0) begin
                    Rout = onehot(y);
                    Rin  = onehot(x);
                    DONE = 1'b1;
                    next = IDLE;
                end else if (op == 4'd1) begin
                    DINout = 1'b1;
                    Rin    = onehot(x);
                    DONE   = 1'b1;
                    next   = IDLE;
                end else begin
                    Rout = onehot(x);
                    enA  = 1'b1;
                    next = T2;
                end
            end
            T2: begin
                enGin = 1'b1;
                ALUOP = 3'(op - 4'd2);
                // NOT takes only the A operand, so the bus stays undriven.
                if (op != 4'd7)
                    Rout = onehot(y);
                next = T3;
            end
            T3: begin
                enGout = 1'b1;
                Rin    = onehot(x);
                DONE   = 1'b1;
                next   = IDLE;
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            TRAP: begin
                ILLEGAL = 1'b1;
            end
`endif
            default: next = IDLE;
        endcase
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer; the reference model expands each
// accepted instruction into a queue of expected per-cycle output records.
module tb_alu_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [9:0] INSTR = '0;
    logic       RUN = 1'b0;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       DINout;
    logic       enA;
    logic       enGin;
    logic       enGout;
    logic [2:0] ALUOP;
    logic       BUSY;
    logic       DONE;
    logic       ill_o;

    alu_sequencer #(.N(10), .NREG(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .INSTR(INSTR),
        .RUN(RUN),
        .Rin(Rin),
        .Rout(Rout),
        .DINout(DINout),
        .enA(enA),
        .enGin(enGin),
        .enGout(enGout),
        .ALUOP(ALUOP),
        .BUSY(BUSY),
        .DONE(DONE)
`ifdef SEQ_ILLEGAL_TRAP_EN
        ,
        .ILLEGAL(ill_o)
`endif
    );

`ifndef SEQ_ILLEGAL_TRAP_EN
    assign ill_o = 1'b0;
`endif

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] rin;
        logic [7:0] rout;
        logic [2:0] aluop;
        logic       dinout;
        logic       ena;
        logic       engin;
        logic       engout;
        logic       busy;
        logic       done;
        logic       ill;
    } rec_t;

    rec_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] reg_bit(input int unsigned r);
        logic [7:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    // Expand one instruction into the output records of the steps it occupies.
    task automatic build(input logic [9:0] ins);
        int unsigned opc;
        int unsigned rx;
        int unsigned ry;
        rec_t r;
        opc = int'(ins[9:6]);
        rx  = int'(ins[5:3]);
        ry  = int'(ins[2:0]);
        r = '0;
        r.busy = 1'b1;
        if (opc >= 8) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            q.push_back(r);
            r.ill = 1'b1;
            q.push_back(r);
`else
            r.done = 1'b1;
            q.push_back(r);
`endif
        end else if (opc == 0) begin
            r.rin = reg_bit(rx); r.rout = reg_bit(ry); r.done = 1'b1;
            q.push_back(r);
        end else if (opc == 1) begin
            r.rin = reg_bit(rx); r.dinout = 1'b1; r.done = 1'b1;
            q.push_back(r);
        end else begin
            r.rout = reg_bit(rx); r.ena = 1'b1;
            q.push_back(r);
            r = '0; r.busy = 1'b1; r.engin = 1'b1;
            r.aluop = 3'(opc - 2);
            r.rout = (opc == 7) ? 8'h00 : reg_bit(ry);
            q.push_back(r);
            r = '0; r.busy = 1'b1; r.engout = 1'b1; r.rin = reg_bit(rx); r.done = 1'b1;
            q.push_back(r);
        end
    endtask

    task automatic cycle(input logic rst, input logic run, input logic [9:0] ins);
        rec_t exp;
        rec_t got;
        int   drivers;
        logic bus_ok;
        RST = rst; RUN = run; INSTR = ins;
        @(posedge CLK);
        if (rst)
            q.delete();
        else if (q.size() > 0) begin
            if (!q[0].ill)
                void'(q.pop_front());
        end else if (run)
            build(ins);
        @(negedge CLK);
        exp = (q.size() > 0) ? q[0] : '0;
        got = '{rin: Rin, rout: Rout, aluop: ALUOP, dinout: DINout, ena: enA,
                engin: enGin, engout: enGout, busy: BUSY, done: DONE, ill: ill_o};
        check("outputs", 32'(got), 32'(exp));
        drivers = int'(|Rout) + int'(DINout) + int'(enGout);
        bus_ok = (drivers <= 1) && $onehot0(Rin) && $onehot0(Rout);
        check("bus_invariant", 32'(bus_ok), 32'd1);
    endtask

    initial begin
        logic [9:0] ins;
        // Reset, then ADD R1,R2
        cycle(1'b1, 1'b0, 10'h000);
        cycle(1'b1, 1'b0, 10'h000);
        cycle(1'b0, 1'b1, 10'h08A);
        cycle(1'b0, 1'b0, 10'h3FF);
        cycle(1'b0, 1'b0, 10'h000);
        cycle(1'b0, 1'b0, 10'h000);
        // MVI R5, idle, MV R0,R7
        cycle(1'b0, 1'b1, 10'h068);
        cycle(1'b0, 1'b0, 10'h000);
        cycle(1'b0, 1'b1, 10'h007);
        cycle(1'b0, 1'b0, 10'h000);
        // NOT R4
        cycle(1'b0, 1'b1, 10'h1E0);
        cycle(1'b0, 1'b0, 10'h000);
        cycle(1'b0, 1'b0, 10'h000);
        cycle(1'b0, 1'b0, 10'h000);
        // SUB R6,R1 aborted by reset in T2 while RUN stays high
        cycle(1'b0, 1'b1, 10'h0F1);
        cycle(1'b0, 1'b1, 10'h0F1);
        cycle(1'b1, 1'b1, 10'h0F1);
        cycle(1'b1, 1'b1, 10'h0F1);
        cycle(1'b0, 1'b1, 10'h0F1);
        cycle(1'b0, 1'b0, 10'h000);
        cycle(1'b0, 1'b0, 10'h000);
        cycle(1'b0, 1'b0, 10'h000);
        // ADD R3,R3
        cycle(1'b0, 1'b1, 10'h09B);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 10'h000);
        // Reserved opcode with RUN pulsing afterwards
        cycle(1'b0, 1'b1, 10'h3C0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'(i % 2), 10'h08A);
        cycle(1'b1, 1'b0, 10'h000);
        cycle(1'b0, 1'b0, 10'h000);
        // Random traffic; INSTR keeps changing after acceptance
        for (int i = 0; i < 600; i++) begin
            ins = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) != 0)
                ins[9] = 1'b0;
            cycle(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 2) != 0), ins);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
